multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the register-file/ALU/data-memory execute datapath, one instruction at a time.
- Handshakes with instruction memory and data memory, both of which may stall.
- Drives the datapath's control inputs (we, MemRead, MemWrite, MemtoReg, alu_op, alu_src), the PC/IR write enables, and a retired-instruction counter.
- Sits between the fetch unit (PC, IR) and the execute datapath.

---
 rtl/rv_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_decode.sv | 29 ++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared types and constants for the multi-cycle control slice.
//   state_e  - FSM state encoding (exported on multicycle_ctrl.state_o)
//   class_e  - instruction class latched in DECODE
//   OP_*     - RV32 major opcodes recognised by the decoder
//   ALUOP_*  - alu_op encodings driven to the execute datapath
//   alu_sel  - class -> {alu_op, alu_src} mapping used in EXEC/MEM/WB
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ITYPE   = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_ILLEGAL = 3'd6
  } class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Returns {alu_op, alu_src}; classes with no ALU use get all zeros.
  function automatic logic [2:0] alu_sel(input class_e cls);
    logic [2:0] r;
    r = 3'b000;
    case (cls)
      CLS_RTYPE:            r = {ALUOP_FUNCT, 1'b0};
      CLS_ITYPE:            r = {ALUOP_FUNCT, 1'b1};
      CLS_LOAD, CLS_STORE:  r = {ALUOP_ADD,   1'b1};
      CLS_BRANCH:           r = {ALUOP_BR,    1'b0};
      default:              r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct3 classifier.
//   opcode - IR[6:0]
//   funct3 - IR[14:12]; only BEQ (000) and BNE (001) are legal branches
//   cls    - decoded instruction class
//   legal  - 1 unless cls is CLS_ILLEGAL
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output class_e     cls,
  output logic       legal
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R:      cls = CLS_RTYPE;
      OP_I:      cls = CLS_ITYPE;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = (funct3[2:1] == 2'b00) ? CLS_BRANCH : CLS_ILLEGAL;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FSM sequencing fetch, decode, execute,
// data-memory access and write-back for one instruction at a time.
//   Inputs : clk, rst_n (async, active low), opcode/funct3 (from IR),
//            zero (ALU flag), imem_ack, dmem_ack
//   Outputs: imem_req, ir_we, pc_we, pc_src, we, MemRead, MemWrite,
//            MemtoReg, alu_op, alu_src, retire, illegal, instret, state_o
//
// Handshakes: imem_req is held every FETCH cycle; the cycle imem_ack is seen
// in FETCH is the transfer cycle (ir_we pulses, FSM moves on). MemRead or
// MemWrite is held every MEM cycle; the cycle dmem_ack is seen in MEM
// completes the access. Acks arriving in any other state are ignored.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TRAP_STICKY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             we,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  class_e dec_cls;
  logic   dec_legal;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  // BEQ takes on zero, BNE on ~zero; funct3[0] picks which.
  logic taken;
  assign taken = funct3[0] ? ~zero : zero;

  logic [2:0] alu_cfg;
  assign alu_cfg = alu_sel(class_q);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    case (state_q)
      ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = dec_cls;
        state_d = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        case (class_q)
          CLS_RTYPE, CLS_ITYPE: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BRANCH:           state_d = ST_FETCH;
          default:              state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = (TRAP_STICKY != 0) ? ST_TRAP : ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  // Output decode from state and latched class. The FETCH outputs are
  // gated with rst_n so that every control is quiet while reset is held,
  // even though the state register already reads FETCH.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    we       = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    alu_op   = 2'b00;
    alu_src  = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = rst_n;
        ir_we    = rst_n & imem_ack;
      end
      ST_EXEC: begin
        {alu_op, alu_src} = alu_cfg;
        if (class_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = taken;
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        // ALU config is held so the datapath keeps presenting the address.
        {alu_op, alu_src} = alu_cfg;
        MemRead  = (class_q == CLS_LOAD);
        MemWrite = (class_q == CLS_STORE);
        if (class_q == CLS_STORE && dmem_ack) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        {alu_op, alu_src} = alu_cfg;
        we       = 1'b1;
        MemtoReg = (class_q == CLS_LOAD);
        pc_we    = 1'b1;
        retire   = 1'b1;
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;

  logic        imem_req, ir_we, pc_we, pc_src, we, mem_read, mem_write, mem_to_reg;
  logic [1:0]  alu_op;
  logic        alu_src, retire, illegal;
  logic [31:0] instret;
  logic [2:0]  state_o;

  logic        imem_req_w, ir_we_w, pc_we_w, pc_src_w, we_w, mem_read_w, mem_write_w, mem_to_reg_w;
  logic [1:0]  alu_op_w;
  logic        alu_src_w, retire_w, illegal_w;
  logic [3:0]  instret_w;
  logic [2:0]  state_o_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .TRAP_STICKY(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .we(we), .MemRead(mem_read), .MemWrite(mem_write),
    .MemtoReg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src), .retire(retire),
    .illegal(illegal), .instret(instret), .state_o(state_o)
  );

  // Narrow counter, non-sticky trap; shares all inputs with dut.
  multicycle_ctrl #(.CNT_W(4), .TRAP_STICKY(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req_w), .ir_we(ir_we_w),
    .pc_we(pc_we_w), .pc_src(pc_src_w), .we(we_w), .MemRead(mem_read_w), .MemWrite(mem_write_w),
    .MemtoReg(mem_to_reg_w), .alu_op(alu_op_w), .alu_src(alu_src_w), .retire(retire_w),
    .illegal(illegal_w), .instret(instret_w), .state_o(state_o_w)
  );

  // {imem_req, ir_we, pc_we, pc_src, we, MemRead, MemWrite, MemtoReg, alu_op, alu_src, retire, illegal, state}
  wire [15:0] obs   = {imem_req, ir_we, pc_we, pc_src, we, mem_read, mem_write, mem_to_reg,
                       alu_op, alu_src, retire, illegal, state_o};
  wire [15:0] obs_w = {imem_req_w, ir_we_w, pc_we_w, pc_src_w, we_w, mem_read_w, mem_write_w,
                       mem_to_reg_w, alu_op_w, alu_src_w, retire_w, illegal_w, state_o_w};

  function automatic logic [15:0] ev(input logic req, irw, pcw, pcs, w, mr, mw, m2r,
                                     input logic [1:0] aop, input logic asrc, ret, ill,
                                     input logic [2:0] st);
    return {req, irw, pcw, pcs, w, mr, mw, m2r, aop, asrc, ret, ill, st};
  endfunction

  // Common expected vectors.
  logic [15:0] E_IDLE_FETCH, E_FETCH_ACK, E_DECODE, E_TRAP, E_RESET;
  initial begin
    E_IDLE_FETCH = ev(1,0,0,0,0,0,0,0,2'b00,0,0,0,3'd0);
    E_FETCH_ACK  = ev(1,1,0,0,0,0,0,0,2'b00,0,0,0,3'd0);
    E_DECODE     = ev(0,0,0,0,0,0,0,0,2'b00,0,0,0,3'd1);
    E_TRAP       = ev(0,0,0,0,0,0,0,0,2'b00,0,0,1,3'd5);
    E_RESET      = ev(0,0,0,0,0,0,0,0,2'b00,0,0,0,3'd0);
  end

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== E_RESET) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, E_RESET); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret obs=%0d exp=0", instret); end
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE_FETCH) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, E_IDLE_FETCH); end
  endtask

  task automatic test_add();
    logic [15:0] e [6];
    logic        ia [6];
    opcode = 7'b0110011; funct3 = 3'b000;
    e  = '{E_IDLE_FETCH, E_IDLE_FETCH, E_FETCH_ACK, E_DECODE,
           ev(0,0,0,0,0,0,0,0,2'b10,0,0,0,3'd2),
           ev(0,0,1,0,1,0,0,0,2'b10,0,1,0,3'd4)};
    ia = '{0, 0, 1, 0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); imem_ack = ia[c]; dmem_ack = 1'b0; #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL add_cyc%0d obs=%h exp=%h", c, obs, e[c]); end
      checks++;
      if (obs_w !== e[c]) begin errors++; $display("FAIL add_w_cyc%0d obs=%h exp=%h", c, obs_w, e[c]); end
      if (c == 0) begin
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL add_instret_before obs=%0d exp=0", instret); end
      end
    end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++;
    if (instret !== 32'd1) begin errors++; $display("FAIL add_instret obs=%0d exp=1", instret); end
  endtask

  task automatic test_load();
    logic [15:0] e [8];
    logic        ia [8];
    logic        da [8];
    logic [15:0] m;
    opcode = 7'b0000011; funct3 = 3'b010;
    m  = ev(0,0,0,0,0,1,0,0,2'b00,1,0,0,3'd3);
    e  = '{E_FETCH_ACK, E_DECODE, ev(0,0,0,0,0,0,0,0,2'b00,1,0,0,3'd2), m, m, m, m,
           ev(0,0,1,0,1,0,0,1,2'b00,1,1,0,3'd4)};
    ia = '{1, 0, 0, 0, 0, 0, 0, 0};
    da = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); imem_ack = ia[c]; dmem_ack = da[c]; #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL load_cyc%0d obs=%h exp=%h", c, obs, e[c]); end
      checks++;
      if (obs_w !== e[c]) begin errors++; $display("FAIL load_w_cyc%0d obs=%h exp=%h", c, obs_w, e[c]); end
    end
    @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    checks++;
    if (instret !== 32'd2) begin errors++; $display("FAIL load_instret obs=%0d exp=2", instret); end
  endtask

  task automatic test_store();
    logic [15:0] e [4];
    logic        ia [4];
    logic        da [4];
    opcode = 7'b0100011; funct3 = 3'b010;
    e  = '{E_FETCH_ACK, E_DECODE, ev(0,0,0,0,0,0,0,0,2'b00,1,0,0,3'd2),
           ev(0,0,1,0,0,0,1,0,2'b00,1,1,0,3'd3)};
    ia = '{1, 0, 0, 0};
    da = '{0, 0, 0, 1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); imem_ack = ia[c]; dmem_ack = da[c]; #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL store_cyc%0d obs=%h exp=%h", c, obs, e[c]); end
      checks++;
      if (obs_w !== e[c]) begin errors++; $display("FAIL store_w_cyc%0d obs=%h exp=%h", c, obs_w, e[c]); end
    end
    @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    checks++;
    if (instret !== 32'd3) begin errors++; $display("FAIL store_instret obs=%0d exp=3", instret); end
  endtask

  // Two branches: BEQ with zero=1 (taken) then BNE with zero=1 (not taken).
  task automatic test_branch();
    logic [15:0] e [3];
    logic [2:0]  f3 [2];
    logic        tk [2];
    f3 = '{3'b000, 3'b001};
    tk = '{1'b1, 1'b0};
    for (int b = 0; b < 2; b++) begin
      opcode = 7'b1100011; funct3 = f3[b]; zero = 1'b1;
      e = '{E_FETCH_ACK, E_DECODE, ev(0,0,1,tk[b],0,0,0,0,2'b01,0,1,0,3'd2)};
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); imem_ack = (c == 0); dmem_ack = 1'b0; #1;
        checks++;
        if (obs !== e[c]) begin errors++; $display("FAIL branch%0d_cyc%0d obs=%h exp=%h", b, c, obs, e[c]); end
        checks++;
        if (obs_w !== e[c]) begin errors++; $display("FAIL branch%0d_w_cyc%0d obs=%h exp=%h", b, c, obs_w, e[c]); end
      end
    end
    @(negedge clk); imem_ack = 1'b0; zero = 1'b0; #1;
    checks++;
    if (instret !== 32'd5) begin errors++; $display("FAIL branch_instret obs=%0d exp=5", instret); end
  endtask

  task automatic test_trap();
    opcode = 7'b1101111; funct3 = 3'b000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); imem_ack = (c == 0); dmem_ack = (c == 4); #1;
      if (c == 0 || c == 1) begin
        checks++;
        if (obs !== ((c == 0) ? E_FETCH_ACK : E_DECODE)) begin
          errors++; $display("FAIL trap_pre_cyc%0d obs=%h", c, obs);
        end
      end else begin
        checks++;
        if (obs !== E_TRAP) begin errors++; $display("FAIL trap_sticky_cyc%0d obs=%h exp=%h", c, obs, E_TRAP); end
        checks++;
        if (instret !== 32'd5) begin errors++; $display("FAIL trap_instret_cyc%0d obs=%0d exp=5", c, instret); end
        checks++;
        if (obs_w !== ((c == 2) ? E_TRAP : E_IDLE_FETCH)) begin
          errors++; $display("FAIL trap_nonsticky_cyc%0d obs=%h", c, obs_w);
        end
        checks++;
        if (instret_w !== 4'd5) begin errors++; $display("FAIL trap_w_instret_cyc%0d obs=%0d exp=5", c, instret_w); end
      end
    end
    @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b0; #1;
    checks++;
    if (obs !== E_RESET || instret !== 32'd0) begin
      errors++; $display("FAIL trap_reset obs=%h instret=%0d exp=%h/0", obs, instret, E_RESET);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // LW interrupted by reset while MEM waits on dmem_ack.
  task automatic test_reset_mid_mem();
    logic [15:0] m;
    opcode = 7'b0000011; funct3 = 3'b010;
    m = ev(0,0,0,0,0,1,0,0,2'b00,1,0,0,3'd3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); imem_ack = (c == 0); dmem_ack = 1'b0; #1;
    end
    checks++;
    if (obs !== m) begin errors++; $display("FAIL midmem_in_mem obs=%h exp=%h", obs, m); end
    @(negedge clk); rst_n = 1'b0; dmem_ack = 1'b1; #1;
    checks++;
    if (obs !== E_RESET) begin errors++; $display("FAIL midmem_reset obs=%h exp=%h", obs, E_RESET); end
    @(negedge clk); #1;
    checks++;
    if (obs !== E_RESET || instret !== 32'd0) begin
      errors++; $display("FAIL midmem_reset_hold obs=%h instret=%0d", obs, instret);
    end
    @(negedge clk); rst_n = 1'b1; dmem_ack = 1'b0; #1;
    checks++;
    if (obs !== E_IDLE_FETCH) begin errors++; $display("FAIL midmem_release obs=%h exp=%h", obs, E_IDLE_FETCH); end
  endtask

  // 16 zero-wait ADDs with both acks held high: the stray acks in
  // DECODE/EXEC/WB (and dmem_ack in FETCH) must change nothing.
  task automatic test_wrap();
    logic [15:0] e [4];
    opcode = 7'b0110011; funct3 = 3'b000;
    e = '{E_FETCH_ACK, E_DECODE, ev(0,0,0,0,0,0,0,0,2'b10,0,0,0,3'd2),
          ev(0,0,1,0,1,0,0,0,2'b10,0,1,0,3'd4)};
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk); imem_ack = 1'b1; dmem_ack = 1'b1; #1;
        checks++;
        if (obs !== e[c]) begin errors++; $display("FAIL wrap_n%0d_cyc%0d obs=%h exp=%h", n, c, obs, e[c]); end
        checks++;
        if (obs_w !== e[c]) begin errors++; $display("FAIL wrap_w_n%0d_cyc%0d obs=%h exp=%h", n, c, obs_w, e[c]); end
      end
      if (n == 14) begin
        @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b1; #1;
        checks++;
        if (instret_w !== 4'd15) begin errors++; $display("FAIL wrap_pre obs=%0d exp=15", instret_w); end
      end
    end
    @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    checks++;
    if (instret_w !== 4'd0) begin errors++; $display("FAIL wrap_w_instret obs=%0d exp=0", instret_w); end
    checks++;
    if (instret !== 32'd16) begin errors++; $display("FAIL wrap_instret obs=%0d exp=16", instret); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
